// File: rtl/vx_onehot_decoder_pipe.sv
// vx_onehot_decoder_pipe: registered binary-index to one-hot decoder
// with valid/ready flow control and a sticky out-of-range error flag.
// Ports: clk, reset_n (async, active-low); valid_in/index_in/tag_in/
// ready_in input stream; valid_out/onehot_out/tag_out/ready_out output
// stream; error_out sticky out-of-range flag.
// Option: define ONEHOT_DEC_SKID_EN for a two-entry elastic stage with
// a registered ready_in (no ready_out -> ready_in combinational path).
module vx_onehot_decoder_pipe #(
  parameter int N       = 4,
  parameter int REVERSE = 0,
  parameter int TAG_W   = 1,
  parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_in,
  input  logic [LN-1:0]    index_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [N-1:0]     onehot_out,
  output logic [TAG_W-1:0] tag_out,
  input  logic             ready_out,
  output logic             error_out
);

  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    SKID
  } st_e;

  localparam logic [LN:0] N_LIM = (LN+1)'(N);

  st_e              st;
  logic [N-1:0]     dec;
  logic [N-1:0]     oh_q;
  logic [TAG_W-1:0] tag_q;
  logic             err_q;
  logic             in_ok;
  logic             in_fire;
  logic             push;

  always_comb begin
    dec = '0;
    for (int k = 0; k < N; k++) begin
      if (REVERSE == 0)
        dec[k] = (index_in == LN'(k));
      else
        dec[k] = (index_in == LN'(N - 1 - k));
    end
  end

  assign in_ok   = {1'b0, index_in} < N_LIM;
  assign in_fire = valid_in && ready_in;
  // Out-of-range beats complete the handshake but are never stored.
  assign push    = in_fire && in_ok;

`ifdef ONEHOT_DEC_SKID_EN
  logic [N-1:0]     sk_oh;
  logic [TAG_W-1:0] sk_tag;
  logic             rdy_q;

  // rdy_q mirrors "skid empty" as its own flop.
  assign ready_in = rdy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= EMPTY;
      oh_q   <= '0;
      tag_q  <= '0;
      sk_oh  <= '0;
      sk_tag <= '0;
      rdy_q  <= 1'b1;
    end else begin
      unique case (st)
        EMPTY: begin
          if (push) begin
            oh_q  <= dec;
            tag_q <= tag_in;
            st    <= FULL;
          end
        end
        FULL: begin
          if (push && !ready_out) begin
            sk_oh  <= dec;
            sk_tag <= tag_in;
            rdy_q  <= 1'b0;
            st     <= SKID;
          end else if (push) begin
            oh_q  <= dec;
            tag_q <= tag_in;
          end else if (ready_out) begin
            st <= EMPTY;
          end
        end
        SKID: begin
          if (ready_out) begin
            oh_q  <= sk_oh;
            tag_q <= sk_tag;
            rdy_q <= 1'b1;
            st    <= FULL;
          end
        end
        default: begin
          st    <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end
`else
  assign ready_in = reset_n && ((st == EMPTY) || ready_out);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st    <= EMPTY;
      oh_q  <= '0;
      tag_q <= '0;
    end else begin
      if (push) begin
        oh_q  <= dec;
        tag_q <= tag_in;
        st    <= FULL;
      end else if ((st != EMPTY) && ready_out) begin
        st <= EMPTY;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (in_fire && !in_ok)
      err_q <= 1'b1;
  end

  assign valid_out  = (st != EMPTY);
  assign onehot_out = oh_q;
  assign tag_out    = tag_q;
  assign error_out  = err_q;

endmodule

// File: tb/tb_vx_onehot_decoder_pipe.sv
// tb_vx_onehot_decoder_pipe: directed and randomized checks of the
// one-hot decoder pipe (N=4 fwd/rev sharing inputs, N=5 with errors).
module tb_vx_onehot_decoder_pipe;

`ifdef ONEHOT_DEC_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       va, ro_a;
  logic [1:0] ia, ta;
  logic       ri_a, vo_a, er_a;
  logic [3:0] oh_a;
  logic [1:0] to_a;
  logic       ri_b, vo_b, er_b;
  logic [3:0] oh_b;
  logic [1:0] to_b;

  logic       vc, ro_c;
  logic [2:0] ic, tc;
  logic       ri_c, vo_c, er_c;
  logic [4:0] oh_c;
  logic [2:0] to_c;

  int checks = 0;
  int failures = 0;

  vx_onehot_decoder_pipe #(.N(4), .REVERSE(0), .TAG_W(2)) u_a (
    .clk(clk), .reset_n(reset_n),
    .valid_in(va), .index_in(ia), .tag_in(ta), .ready_in(ri_a),
    .valid_out(vo_a), .onehot_out(oh_a), .tag_out(to_a),
    .ready_out(ro_a), .error_out(er_a)
  );

  vx_onehot_decoder_pipe #(.N(4), .REVERSE(1), .TAG_W(2)) u_b (
    .clk(clk), .reset_n(reset_n),
    .valid_in(va), .index_in(ia), .tag_in(ta), .ready_in(ri_b),
    .valid_out(vo_b), .onehot_out(oh_b), .tag_out(to_b),
    .ready_out(ro_a), .error_out(er_b)
  );

  vx_onehot_decoder_pipe #(.N(5), .REVERSE(0), .TAG_W(3)) u_c (
    .clk(clk), .reset_n(reset_n),
    .valid_in(vc), .index_in(ic), .tag_in(tc), .ready_in(ri_c),
    .valid_out(vo_c), .onehot_out(oh_c), .tag_out(to_c),
    .ready_out(ro_c), .error_out(er_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    va = 0; ia = 0; ta = 0; ro_a = 0;
    vc = 0; ic = 0; tc = 0; ro_c = 0;
    reset_n = 0;
    tick(); tick();
    checks++;
    if ({vo_a, oh_a, to_a, er_a} !== 8'h00) begin
      failures++;
      $display("FAIL reset_a got=%h exp=00", {vo_a, oh_a, to_a, er_a});
    end
    checks++;
    if ({vo_c, oh_c, to_c, er_c} !== 10'h000) begin
      failures++;
      $display("FAIL reset_c got=%h exp=000", {vo_c, oh_c, to_c, er_c});
    end
    checks++;
    if ({ri_a, ri_b, ri_c} !== {3{SKID}}) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=%b", {ri_a, ri_b, ri_c}, {3{SKID}});
    end
    reset_n = 1;
    tick();
    checks++;
    if ({ri_a, ri_c, vo_a, vo_b} !== 4'b1100) begin
      failures++;
      $display("FAIL post_reset got=%b exp=1100", {ri_a, ri_c, vo_a, vo_b});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [4];
    logic [3:0] eb [4];
    logic [1:0] tg [4];
    ea = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    eb = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    tg = '{2'd1, 2'd2, 2'd3, 2'd0};
    ro_a = 1;
    for (int i = 0; i < 4; i++) begin
      va = 1; ia = 2'(i); ta = tg[i];
      tick();
      checks++;
      if ({vo_a, oh_a, to_a} !== {1'b1, ea[i], tg[i]}) begin
        failures++;
        $display("FAIL b2b_fwd[%0d] got=%b exp=%b", i,
                 {vo_a, oh_a, to_a}, {1'b1, ea[i], tg[i]});
      end
      checks++;
      if ({vo_b, oh_b, to_b, ri_a} !== {1'b1, eb[i], tg[i], 1'b1}) begin
        failures++;
        $display("FAIL b2b_rev[%0d] got=%b exp=%b", i,
                 {vo_b, oh_b, to_b, ri_a}, {1'b1, eb[i], tg[i], 1'b1});
      end
    end
    va = 0;
    tick();
    checks++;
    if ({vo_a, vo_b} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_idle got=%b exp=00", {vo_a, vo_b});
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] idx [3];
    logic [2:0] tg [3];
    logic [4:0] eoh [3];
    logic [1:0] eve [3];
    idx = '{3'd4, 3'd6, 3'd2};
    tg  = '{3'd5, 3'd6, 3'd7};
    eoh = '{5'b10000, 5'b00000, 5'b00100};
    eve = '{2'b10, 2'b01, 2'b11};
    ro_c = 1;
    for (int i = 0; i < 3; i++) begin
      vc = 1; ic = idx[i]; tc = tg[i];
      tick();
      checks++;
      if ({vo_c, er_c, ri_c} !== {eve[i], 1'b1}) begin
        failures++;
        $display("FAIL oor_valid_err[%0d] got=%b exp=%b", i,
                 {vo_c, er_c, ri_c}, {eve[i], 1'b1});
      end
      if (eve[i][1]) begin
        checks++;
        if ({oh_c, to_c} !== {eoh[i], tg[i]}) begin
          failures++;
          $display("FAIL oor_data[%0d] got=%b exp=%b", i,
                   {oh_c, to_c}, {eoh[i], tg[i]});
        end
      end
    end
    vc = 0;
    tick(); tick();
    checks++;
    if ({vo_c, er_c} !== 2'b01) begin
      failures++;
      $display("FAIL oor_sticky got=%b exp=01", {vo_c, er_c});
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    ro_a = 0;
    va = 1; ia = 2'd1; ta = 2'd1;
    tick();
    checks++;
    if ({vo_a, oh_a, to_a, oh_b} !== {1'b1, 4'b0010, 2'd1, 4'b0100}) begin
      failures++;
      $display("FAIL bp_first got=%b exp=%b", {vo_a, oh_a, to_a, oh_b},
               {1'b1, 4'b0010, 2'd1, 4'b0100});
    end
    checks++;
    if (ri_a !== SKID) begin
      failures++;
      $display("FAIL bp_ready1 got=%b exp=%b", ri_a, SKID);
    end
    ia = 2'd2; ta = 2'd2;
    #1 acc = va && ri_a;
    tick();
    if (acc) va = 0;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({vo_a, oh_a, to_a, ri_a} !== {1'b1, 4'b0010, 2'd1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d] got=%b exp=%b", s, {vo_a, oh_a, to_a, ri_a},
                 {1'b1, 4'b0010, 2'd1, 1'b0});
      end
      if (s == 0) tick();
    end
    ro_a = 1;
    #1 acc = va && ri_a;
    tick();
    if (acc) va = 0;
    checks++;
    if ({vo_a, oh_a, to_a, oh_b, ri_a} !==
        {1'b1, 4'b0100, 2'd2, 4'b0010, 1'b1}) begin
      failures++;
      $display("FAIL bp_release got=%b exp=%b", {vo_a, oh_a, to_a, oh_b, ri_a},
               {1'b1, 4'b0100, 2'd2, 4'b0010, 1'b1});
    end
    tick();
    checks++;
    if ({vo_a, va} !== 2'b00) begin
      failures++;
      $display("FAIL bp_nodup got=%b exp=00", {vo_a, va});
    end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic [7:0] exp, held;
    logic [4:0] one;
    logic       acc, stall;
    one = 5'b00001;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vc   = ($urandom_range(0, 3) != 0);
      ic   = 3'($urandom_range(0, 7));
      tc   = 3'($urandom_range(0, 7));
      ro_c = ($urandom_range(0, 2) != 0);
      #1;
      acc   = vc && ri_c;
      stall = vo_c && !ro_c;
      held  = {to_c, oh_c};
      if (vo_c && ro_c) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra cyc=%0d got=%h exp=none", cyc, held);
        end else begin
          exp = q.pop_front();
          if (held !== exp) begin
            failures++;
            $display("FAIL rand_order cyc=%0d got=%h exp=%h", cyc, held, exp);
          end
        end
      end
      if (acc && ic < 3'd5) q.push_back({tc, one << ic});
      tick();
      if (stall) begin
        checks++;
        if ({vo_c, to_c, oh_c} !== {1'b1, held}) begin
          failures++;
          $display("FAIL rand_stable cyc=%0d got=%h exp=%h", cyc,
                   {vo_c, to_c, oh_c}, {1'b1, held});
        end
      end
    end
    vc = 0; ro_c = 1;
    for (int k = 0; k < 10; k++) begin
      if (vo_c && q.size() != 0) begin
        exp = q.pop_front();
        checks++;
        if ({to_c, oh_c} !== exp) begin
          failures++;
          $display("FAIL rand_drain got=%h exp=%h", {to_c, oh_c}, exp);
        end
      end
      tick();
    end
    checks++;
    if (q.size() != 0 || vo_c !== 1'b0 || er_c !== 1'b1) begin
      failures++;
      $display("FAIL rand_end left=%0d got_valid=%b got_err=%b exp=0,0,1",
               q.size(), vo_c, er_c);
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    ro_a = 0;
    va = 1; ia = 2'd3; ta = 2'd3;
    tick();
    ia = 2'd0; ta = 2'd0;
    #1 acc = va && ri_a;
    tick();
    va = 0;
    #2 reset_n = 0;
    #1;
    checks++;
    if ({vo_a, oh_a, to_a, vo_b, vo_c, er_c} !== 10'h000) begin
      failures++;
      $display("FAIL mrst_clear got=%b exp=0",
               {vo_a, oh_a, to_a, vo_b, vo_c, er_c});
    end
    checks++;
    if (ri_a !== SKID) begin
      failures++;
      $display("FAIL mrst_ready got=%b exp=%b", ri_a, SKID);
    end
    @(posedge clk);
    #2 reset_n = 1;
    ro_a = 1;
    tick();
    tick();
    checks++;
    if ({vo_a, vo_b, ri_a} !== 3'b001) begin
      failures++;
      $display("FAIL mrst_nostale got=%b exp=001", {vo_a, vo_b, ri_a});
    end
    va = 1; ia = 2'd2; ta = 2'd1;
    tick();
    va = 0;
    checks++;
    if ({vo_a, oh_a, to_a, oh_b} !== {1'b1, 4'b0100, 2'd1, 4'b0010}) begin
      failures++;
      $display("FAIL mrst_first got=%b exp=%b", {vo_a, oh_a, to_a, oh_b},
               {1'b1, 4'b0100, 2'd1, 4'b0010});
    end
    tick();
    checks++;
    if ({vo_a, er_a, er_b} !== 3'b000) begin
      failures++;
      $display("FAIL mrst_after got=%b exp=000", {vo_a, er_a, er_b});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_out_of_range();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vx_onehot_decoder_pipe.md
# vx_onehot_decoder_pipe

Registered, flow-controlled binary-index-to-one-hot decoder: the inverse of the one-hot encoder used by arbiters and schedulers. It accepts a binary index plus a sideband tag on a valid/ready stream and emits the matching N-bit one-hot vector one cycle later. Typical uses are turning a selected warp or thread index back into a lane mask, or a bank index into a bank-enable vector, on paths that need a register stage and backpressure.

## Interface
- `N`, default 4: one-hot output width; N ≥ 2.
- `REVERSE`, default 0: 0 maps index i to bit i; 1 maps index i to bit N-1-i.
- `TAG_W`, default 1: sideband tag width, passed through unchanged; TAG_W ≥ 1.
- `LN`, default `LOG2UP(N)`: index width; not to be overridden.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: input index valid.
- `index_in` in LN: binary index.
- `tag_in` in TAG_W: sideband tag.
- `ready_in` out 1: block can accept the input.
- `valid_out` out 1: output vector valid.
- `onehot_out` out N: decoded one-hot vector.
- `tag_out` out TAG_W: tag associated with `onehot_out`.
- `ready_out` in 1: downstream accepts the output.
- `error_out` out 1: sticky flag; an out-of-range index was received.

## Operation
- Input transfer happens when `valid_in && ready_in`. Output transfer happens when `valid_out && ready_out`.
- Decode: `onehot_out[k]` = 1 iff k == `index_in` (REVERSE=0) or k == N-1-`index_in` (REVERSE=1). Exactly one bit is set for every emitted beat.
- Out-of-range index (`index_in` ≥ N, possible only when N is not a power of two):
  - the beat is consumed (handshake completes) and dropped;
  - no output beat is produced;
  - `error_out` sets on the following edge and stays 1 until reset.
- The tag travels with its beat. Beats are never reordered, duplicated or lost, except for dropped out-of-range beats.
- Output stage states: EMPTY (`valid_out`=0) and FULL (`valid_out`=1). With skid enabled there is an additional SKID state (FULL plus one held beat).
  - EMPTY → FULL on an accepted in-range input.
  - FULL → EMPTY on an output transfer with no in-range input accepted in the same cycle.
  - FULL → FULL on a simultaneous output transfer and in-range input.
  - FULL → SKID (skid only) on an input accepted while `ready_out`=0.
  - SKID → FULL on an output transfer; the held beat moves to the output.
- While `valid_out`=1 and `ready_out`=0, `onehot_out` and `tag_out` must not change.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `valid_out`=0, `onehot_out`=0, `tag_out`=0, `error_out`=0, skid empty;
  - `ready_in`=1 during reset with skid enabled, and 0 during reset without skid.
- Latency: a beat accepted at edge t is on `onehot_out` with `valid_out`=1 after edge t, i.e. visible in cycle t+1.
- Throughput: one beat per cycle while `ready_out`=1.
- Mid-operation reset: all in-flight beats are discarded and no partial beat is emitted after release. The first beat after release follows the latency rule above.
- `valid_in` must not depend combinationally on `ready_in`. `valid_out` never depends combinationally on any input.
- `error_out` timing: rises the cycle after the offending input handshake, including when that handshake coincides with an output transfer.

## Configuration
- `ONEHOT_DEC_SKID_EN` defined:
  - a two-entry elastic stage (output register plus skid register);
  - `ready_in` is a register output equal to "skid empty";
  - there is no combinational path from `ready_out` to `ready_in`;
  - full throughput is preserved under backpressure toggling.
- `ONEHOT_DEC_SKID_EN` undefined:
  - a single output register;
  - `ready_in` = `reset_n` && (!`valid_out` || `ready_out`), which is combinational from `ready_out`;
  - the SKID state does not exist.
- Functional behaviour, latency and ordering are identical in both builds; only the `ready_in` timing differs.

## Test plan
- N=4, REVERSE=0, `ready_out`=1; input indices 0,1,2,3 with tags 0,1,0,1 back-to-back → outputs 0001, 0010, 0100, 1000 with matching tags, one per cycle, first at cycle t+1.
- N=4, REVERSE=1; index 0 → 1000, index 3 → 0001.
- N=5; stream indices 4, 6, 2 → outputs 10000 then 00100 only; `error_out` rises the cycle after index 6 is accepted and stays 1 for the rest of the test.
- N=8 with skid; hold `ready_out`=0 while sending indices 1, 5 → `ready_in` drops after the second accept and `onehot_out` stays at 00000010. Release `ready_out` → 00000010 then 00100000, no gap, no loss.
- Random `valid_in`/`ready_out` for 10k cycles in both builds → the output sequence equals the scoreboard of in-range inputs in order, and `onehot_out` is stable while stalled.
- Assert `reset_n`=0 for one cycle while FULL (and SKID) → `valid_out`=0 immediately, `error_out`=0, and no stale beat appears after release.
